ghost_collision_arbiter: RTL and testbench

// Pac-Man/ghost interaction arbiter; the producer of the per-ghost eaten/returned events that the ghost mode controller consumes.
// On each movement tick it compares Pac-Man's tile against all four ghost tiles, using each ghost's current mode.
// It issues eat events, Pac-Man death, the ghost-eat combo score and the eat freeze, and reports when eyes reach the ghost house.

---
 rtl/ghost_collision_arbiter_pkg.sv | 38 +++
 rtl/ghost_collision_arbiter_return.sv | 45 ++++
 rtl/ghost_collision_arbiter.sv | 156 +++++++++++++++
 tb/tb_ghost_collision_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_collision_arbiter_pkg.sv
// Shared constants and mode helpers for the ghost collision arbiter.
package ghost_collision_arbiter_pkg;

    localparam int NUM_GHOSTS = 4;

    // Ghost mode encodings as driven by the ghost mode controller.
    localparam logic [3:0] MODE_CHASE      = 4'd0;
    localparam logic [3:0] MODE_SCATTER    = 4'd1;
    localparam logic [3:0] MODE_FRIGHTENED = 4'd2;
    localparam logic [3:0] MODE_EATEN      = 4'd3;

    // Game FSM code in which collisions are live.
    localparam logic [7:0] GS_PLAYING = 8'd2;

    // Points for the first ghost of a combo; each further ghost doubles it.
    localparam logic [15:0] SCORE_BASE = 16'd200;

    // A ghost that kills Pac-Man on contact.
    function automatic logic mode_is_threat(input logic [3:0] mode);
        return (mode == MODE_CHASE) || (mode == MODE_SCATTER);
    endfunction

    // A ghost that Pac-Man can eat on contact.
    function automatic logic mode_is_frightened(input logic [3:0] mode);
        return (mode == MODE_FRIGHTENED);
    endfunction

    // Eyes, plus any unknown code, which is deliberately handled the same way.
    function automatic logic mode_is_eaten(input logic [3:0] mode);
        return !mode_is_threat(mode) && !mode_is_frightened(mode);
    endfunction

    // Score for an eat at the given combo level (0..3 -> 200..1600).
    function automatic logic [15:0] combo_score(input logic [1:0] combo);
        return SCORE_BASE << combo;
    endfunction

endpackage

// File: rtl/ghost_collision_arbiter_return.sv
// One ghost's eyes-home detector: a single pulse per trip back to the house.
module ghost_return_detector
    import ghost_collision_arbiter_pkg::*;
#(
    parameter int POS_W   = 5,
    parameter int HOUSE_X = 13,
    parameter int HOUSE_Y = 14
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_eval,
    input  logic [POS_W-1:0] i_x,
    input  logic [POS_W-1:0] i_y,
    input  logic [3:0]       i_mode,
    output logic             o_returned
);

    logic w_is_eaten;
    logic w_at_home;
    logic r_home;
    logic r_returned;

    assign w_is_eaten = mode_is_eaten(i_mode);
    assign w_at_home  = (i_x == POS_W'(HOUSE_X)) && (i_y == POS_W'(HOUSE_Y));

    // Home flag arms on arrival and disarms as soon as the ghost leaves eyes mode.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_home     <= 1'b0;
            r_returned <= 1'b0;
        end else begin
            r_returned <= 1'b0;
            if (!w_is_eaten) begin
                r_home <= 1'b0;
            end else if (i_eval && w_at_home && !r_home) begin
                r_home     <= 1'b1;
                r_returned <= 1'b1;
            end
        end
    end

    assign o_returned = r_returned;

endmodule

// File: rtl/ghost_collision_arbiter.sv
// Pac-Man / ghost collision arbiter: death, eat events, combo score, eat freeze
// and eyes-home reporting, all sampled on the movement tick.
module ghost_collision_arbiter
    import ghost_collision_arbiter_pkg::*;
#(
    parameter int POS_W      = 5,
    parameter int HOUSE_X    = 13,
    parameter int HOUSE_Y    = 14,
    parameter int FREEZE_CYC = 50000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_game_state,
    input  logic                    i_tick,
    input  logic                    i_ghost_reload,
    input  logic                    i_energizers_eaten,
    input  logic [POS_W-1:0]        i_pac_x,
    input  logic [POS_W-1:0]        i_pac_y,
    input  logic [4*POS_W-1:0]      i_ghost_x,
    input  logic [4*POS_W-1:0]      i_ghost_y,
    input  logic [15:0]             i_ghost_state,
    output logic [3:0]              o_eaten,
    output logic [3:0]              o_returned,
    output logic                    o_pacman_caught,
    output logic                    o_score_valid,
    output logic [15:0]             o_score_add,
    output logic                    o_freeze
);

    localparam int CNT_W = $clog2(FREEZE_CYC + 1);

    logic [NUM_GHOSTS-1:0] w_coll;
    logic [NUM_GHOSTS-1:0] w_threat;
    logic [NUM_GHOSTS-1:0] w_fright;
    logic [NUM_GHOSTS-1:0] w_eat_sel;
    logic                  w_found;
    logic                  w_freeze_active;
    logic                  w_eval;
    logic                  w_caught_now;
    logic                  w_eat_now;
    logic [1:0]            w_combo_eff;

    logic [CNT_W-1:0]      r_freeze_cnt;
    logic [1:0]            r_combo;
    logic                  r_caught;
    logic [3:0]            r_eaten;
    logic                  r_caught_pulse;
    logic                  r_score_valid;
    logic [15:0]           r_score_add;

    // Per-ghost tile compare, mode classification and eyes-home detector.
    generate
        for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
            logic [POS_W-1:0] w_gx;
            logic [POS_W-1:0] w_gy;
            logic [3:0]       w_mode;

            assign w_gx   = i_ghost_x[gi*POS_W +: POS_W];
            assign w_gy   = i_ghost_y[gi*POS_W +: POS_W];
            assign w_mode = i_ghost_state[gi*4 +: 4];

            assign w_coll[gi]   = (w_gx == i_pac_x) && (w_gy == i_pac_y);
            assign w_threat[gi] = w_coll[gi] && mode_is_threat(w_mode);
            assign w_fright[gi] = w_coll[gi] && mode_is_frightened(w_mode);

            ghost_return_detector #(
                .POS_W   (POS_W),
                .HOUSE_X (HOUSE_X),
                .HOUSE_Y (HOUSE_Y)
            ) u_return (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_clear    (i_ghost_reload),
                .i_eval     (i_tick && !r_caught),
                .i_x        (w_gx),
                .i_y        (w_gy),
                .i_mode     (w_mode),
                .o_returned (o_returned[gi])
            );
        end
    endgenerate

    // Lowest-index frightened ghost on Pac's tile wins the single eat slot.
    always_comb begin
        w_eat_sel = '0;
        w_found   = 1'b0;
        for (int g = 0; g < NUM_GHOSTS; g++) begin
            if (w_fright[g] && !w_found) begin
                w_eat_sel[g] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign w_freeze_active = (r_freeze_cnt != '0);
    assign w_eval          = i_tick && (i_game_state == GS_PLAYING)
                             && !w_freeze_active && !r_caught;
    // Any deadly contact pre-empts eating anything that tick.
    assign w_caught_now    = w_eval && (|w_threat);
    assign w_eat_now       = w_eval && !(|w_threat) && (|w_fright);
    // An energizer in the same cycle restarts the combo before this eat scores.
    assign w_combo_eff     = i_energizers_eaten ? 2'd0 : r_combo;

    // Event outputs: one-cycle pulses registered from the evaluated tick.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_ghost_reload) begin
            r_eaten        <= '0;
            r_caught_pulse <= 1'b0;
            r_score_valid  <= 1'b0;
            r_score_add    <= '0;
        end else begin
            r_eaten        <= w_eat_now ? w_eat_sel : 4'd0;
            r_caught_pulse <= w_caught_now;
            r_score_valid  <= w_eat_now;
            r_score_add    <= w_eat_now ? combo_score(w_combo_eff) : 16'd0;
        end
    end

    // Combo level saturates at 3 (1600 points) until an energizer restarts it.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_ghost_reload) begin
            r_combo <= 2'd0;
        end else if (w_eat_now) begin
            r_combo <= (w_combo_eff == 2'd3) ? 2'd3 : w_combo_eff + 2'd1;
        end else begin
            r_combo <= w_combo_eff;
        end
    end

    // Caught latch freezes all evaluation until the next level/life restart.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_ghost_reload) begin
            r_caught <= 1'b0;
        end else if (w_caught_now) begin
            r_caught <= 1'b1;
        end
    end

    // Eat pause counter; loads on an eat and drains regardless of game state.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_ghost_reload) begin
            r_freeze_cnt <= '0;
        end else if (w_eat_now) begin
            r_freeze_cnt <= CNT_W'(FREEZE_CYC);
        end else if (w_freeze_active) begin
            r_freeze_cnt <= r_freeze_cnt - CNT_W'(1);
        end
    end

    assign o_eaten         = r_eaten;
    assign o_pacman_caught = r_caught_pulse;
    assign o_score_valid   = r_score_valid;
    assign o_score_add     = r_score_add;
    assign o_freeze        = w_freeze_active;

endmodule

// File: tb/tb_ghost_collision_arbiter.sv
// Testbench for ghost_collision_arbiter: directed scenarios plus randomized
// traffic, all checked against a game-rule reference model.
module tb_ghost_collision_arbiter;

    localparam int POS_W  = 5;
    localparam int FRZ    = 8;
    localparam int HX     = 13;
    localparam int HY     = 14;
    localparam logic [7:0] PLAY = 8'd2;

    logic                 clk;
    logic                 rst;
    logic [7:0]           gs;
    logic                 tick;
    logic                 reload;
    logic                 energ;
    logic [POS_W-1:0]     pac_x, pac_y;
    logic [POS_W-1:0]     gx [4];
    logic [POS_W-1:0]     gy [4];
    logic [3:0]           gm [4];
    logic [4*POS_W-1:0]   w_gx, w_gy;
    logic [15:0]          w_gm;

    logic [3:0]  o_eaten, o_returned;
    logic        o_pacman_caught, o_score_valid, o_freeze;
    logic [15:0] o_score_add;
    logic [26:0] w_obs;

    assign w_gx  = {gx[3], gx[2], gx[1], gx[0]};
    assign w_gy  = {gy[3], gy[2], gy[1], gy[0]};
    assign w_gm  = {gm[3], gm[2], gm[1], gm[0]};
    assign w_obs = {o_eaten, o_returned, o_pacman_caught, o_score_valid, o_score_add, o_freeze};

    ghost_collision_arbiter #(
        .POS_W(POS_W), .HOUSE_X(HX), .HOUSE_Y(HY), .FREEZE_CYC(FRZ)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_game_state(gs), .i_tick(tick),
        .i_ghost_reload(reload), .i_energizers_eaten(energ),
        .i_pac_x(pac_x), .i_pac_y(pac_y), .i_ghost_x(w_gx), .i_ghost_y(w_gy),
        .i_ghost_state(w_gm), .o_eaten(o_eaten), .o_returned(o_returned),
        .o_pacman_caught(o_pacman_caught), .o_score_valid(o_score_valid),
        .o_score_add(o_score_add), .o_freeze(o_freeze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, in game terms.
    int          m_combo;      // ghosts eaten since last energizer, capped at 3
    int          m_freeze;     // cycles of eat pause still to run
    bit          m_dead;       // Pac-Man caught, waiting for a restart
    bit [3:0]    m_home;       // eyes already reported home this trip
    logic [26:0] exp_vec;

    // Predict the outputs that appear after the coming clock edge.
    task automatic model_step();
        logic [3:0] e_eat, e_ret;
        bit         e_dead, e_sv, threat;
        int         e_pts, lvl, eat_g;
        bit         ate;
        e_eat = 0; e_ret = 0; e_dead = 0; e_sv = 0; e_pts = 0; eat_g = -1; threat = 0; ate = 0;
        if (rst || reload) begin
            m_combo = 0; m_freeze = 0; m_dead = 0; m_home = 0;
            exp_vec = '0;
            return;
        end
        lvl = energ ? 0 : m_combo;
        for (int g = 0; g < 4; g++) begin
            bit eyes;
            eyes = (gm[g] > 4'd2);
            if (!eyes) m_home[g] = 0;
            else if (tick && !m_dead && gx[g] == HX && gy[g] == HY && !m_home[g]) begin
                e_ret[g] = 1; m_home[g] = 1;
            end
        end
        if (tick && gs == PLAY && m_freeze == 0 && !m_dead) begin
            for (int g = 0; g < 4; g++) begin
                if (gx[g] == pac_x && gy[g] == pac_y) begin
                    if (gm[g] < 4'd2) threat = 1;
                    else if (gm[g] == 4'd2 && eat_g < 0) eat_g = g;
                end
            end
        end
        if (threat) begin
            e_dead = 1; m_dead = 1;
        end else if (eat_g >= 0) begin
            e_eat[eat_g] = 1; e_sv = 1;
            e_pts = 200 * (1 << lvl);
            lvl = (lvl + 1 > 3) ? 3 : lvl + 1;
            ate = 1;
        end
        if (ate) m_freeze = FRZ;
        else if (m_freeze > 0) m_freeze--;
        m_combo = lvl;
        exp_vec = {e_eat, e_ret, e_dead, e_sv, e_pts[15:0], (m_freeze > 0)};
    endtask

    // Advance one clock with the current inputs; strobes drop afterwards.
    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
        tick = 0; energ = 0; reload = 0;
    endtask

    task automatic place(input int g, input int x, input int y, input logic [3:0] m);
        gx[g] = POS_W'(x); gy[g] = POS_W'(y); gm[g] = m;
    endtask

    task automatic park_all();
        for (int g = 0; g < 4; g++) place(g, 20 + g, 1, 4'd0);
        pac_x = 5; pac_y = 5; gs = PLAY;
    endtask

    task automatic test_reset();
        park_all();
        rst = 1; tick = 1; energ = 1;
        adv();
        rst = 0;
        if (w_obs !== 27'd0) begin
            n_err++; $display("FAIL reset got %h want 0", w_obs);
        end
        n_vec++;
        reload = 1;
        adv();
        if (w_obs !== exp_vec) begin
            n_err++; $display("FAIL reset_reload got %h want %h", w_obs, exp_vec);
        end
        n_vec++;
    endtask

    task automatic test_single_eat();
        int fz;
        park_all(); place(0, 5, 5, 4'd2);
        tick = 1;
        adv();
        if (o_eaten !== 4'b0001 || o_score_add !== 16'd200 || o_score_valid !== 1'b1 || o_freeze !== 1'b1) begin
            n_err++; $display("FAIL single_eat got eaten=%b pts=%0d sv=%b fz=%b want 0001/200/1/1",
                              o_eaten, o_score_add, o_score_valid, o_freeze);
        end
        n_vec++;
        fz = 1;
        place(0, 5, 5, 4'd3);
        for (int c = 0; c < 12; c++) begin
            adv();
            fz += int'(o_freeze);
            if (w_obs !== exp_vec) begin
                n_err++; $display("FAIL single_eat_cyc%0d got %h want %h", c, w_obs, exp_vec);
            end
            n_vec++;
        end
        if (fz !== FRZ) begin
            n_err++; $display("FAIL freeze_len got %0d want %0d", fz, FRZ);
        end
        n_vec++;
    endtask

    task automatic test_combo();
        int want [6] = '{200, 400, 800, 1600, 1600, 200};
        park_all(); reload = 1; adv();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin energ = 1; adv(); end
            place(0, 5, 5, 4'd2);
            tick = 1;
            adv();
            if (o_score_add !== 16'(want[k]) || o_eaten !== 4'b0001) begin
                n_err++; $display("FAIL combo_%0d got pts=%0d eaten=%b want %0d/0001", k, o_score_add, o_eaten, want[k]);
            end
            n_vec++;
            place(0, 5, 5, 4'd3);
            for (int c = 0; c < FRZ + 1; c++) begin
                adv();
                if (w_obs !== exp_vec) begin
                    n_err++; $display("FAIL combo_wait got %h want %h", w_obs, exp_vec);
                end
                n_vec++;
            end
        end
    endtask

    task automatic test_caught();
        park_all(); reload = 1; adv();
        place(1, 5, 5, 4'd2); place(2, 5, 5, 4'd0);
        tick = 1;
        adv();
        if (o_pacman_caught !== 1'b1 || o_eaten !== 4'b0000 || o_score_valid !== 1'b0) begin
            n_err++; $display("FAIL caught got caught=%b eaten=%b want 1/0000", o_pacman_caught, o_eaten);
        end
        n_vec++;
        place(2, HX, HY, 4'd3); place(0, 5, 5, 4'd2);
        for (int c = 0; c < 8; c++) begin
            tick = c[0];
            adv();
            if (w_obs !== 27'd0) begin
                n_err++; $display("FAIL caught_hold got %h want 0", w_obs);
            end
            n_vec++;
        end
        reload = 1; tick = 1;
        adv();
        if (w_obs !== 27'd0) begin
            n_err++; $display("FAIL reload_prio got %h want 0", w_obs);
        end
        n_vec++;
        tick = 1;
        adv();
        if (w_obs !== exp_vec || o_eaten !== 4'b0001) begin
            n_err++; $display("FAIL after_reload got %h want %h", w_obs, exp_vec);
        end
        n_vec++;
    endtask

    task automatic test_double_coll();
        park_all(); reload = 1; adv();
        place(0, 5, 5, 4'd2); place(3, 5, 5, 4'd2);
        tick = 1;
        adv();
        if (o_eaten !== 4'b0001 || o_score_add !== 16'd200) begin
            n_err++; $display("FAIL double_first got eaten=%b pts=%0d want 0001/200", o_eaten, o_score_add);
        end
        n_vec++;
        place(0, 5, 5, 4'd3);
        for (int c = 0; c < FRZ + 2; c++) begin
            tick = (c == 3);
            adv();
            if (w_obs !== exp_vec) begin
                n_err++; $display("FAIL double_wait got %h want %h", w_obs, exp_vec);
            end
            n_vec++;
        end
        tick = 1;
        adv();
        if (o_eaten !== 4'b1000 || o_score_add !== 16'd400) begin
            n_err++; $display("FAIL double_second got eaten=%b pts=%0d want 1000/400", o_eaten, o_score_add);
        end
        n_vec++;
    endtask

    task automatic test_return();
        int pulses;
        park_all(); reload = 1; adv();
        place(2, HX, HY, 4'd3);
        pulses = 0;
        for (int c = 0; c < 9; c++) begin
            tick = (c % 3 == 0);
            adv();
            pulses += int'(o_returned[2]);
            if (w_obs !== exp_vec) begin
                n_err++; $display("FAIL return_cyc%0d got %h want %h", c, w_obs, exp_vec);
            end
            n_vec++;
        end
        if (pulses !== 1) begin
            n_err++; $display("FAIL return_once got %0d pulses want 1", pulses);
        end
        n_vec++;
        gm[2] = 4'd0; adv();
        gm[2] = 4'd3; tick = 1; adv();
        pulses += int'(o_returned[2]);
        if (pulses !== 2 || o_returned !== 4'b0100) begin
            n_err++; $display("FAIL return_again got %0d pulses ret=%b want 2/0100", pulses, o_returned);
        end
        n_vec++;
    endtask

    task automatic test_rst_energizer();
        park_all(); reload = 1; adv();
        place(0, 5, 5, 4'd2); tick = 1; adv();
        place(0, 5, 5, 4'd3); adv(); adv(); adv();
        rst = 1;
        adv();
        rst = 0;
        if (w_obs !== 27'd0) begin
            n_err++; $display("FAIL rst_midfreeze got %h want 0", w_obs);
        end
        n_vec++;
        place(0, 5, 5, 4'd2); tick = 1; adv();
        if (o_score_add !== 16'd200) begin
            n_err++; $display("FAIL rst_combo got pts=%0d want 200", o_score_add);
        end
        n_vec++;
        place(0, 5, 5, 4'd3);
        repeat (FRZ) adv();
        place(1, 5, 5, 4'd2); tick = 1; energ = 1;
        adv();
        if (o_score_add !== 16'd200 || o_eaten !== 4'b0010) begin
            n_err++; $display("FAIL energ_coinc got pts=%0d eaten=%b want 200/0010", o_score_add, o_eaten);
        end
        n_vec++;
    endtask

    task automatic test_random();
        park_all(); reload = 1; adv();
        for (int c = 0; c < 1500; c++) begin
            pac_x = POS_W'($urandom_range(0, 2));
            pac_y = POS_W'($urandom_range(0, 2));
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 3) == 0) begin gx[g] = HX; gy[g] = HY; end
                    else begin gx[g] = POS_W'($urandom_range(0, 2)); gy[g] = POS_W'($urandom_range(0, 2)); end
                end
                if ($urandom_range(0, 7) == 0) gm[g] = 4'($urandom_range(0, 3));
            end
            gs     = ($urandom_range(0, 9) == 0) ? 8'd1 : PLAY;
            tick   = ($urandom_range(0, 2) == 0);
            energ  = ($urandom_range(0, 30) == 0);
            reload = ($urandom_range(0, 80) == 0);
            rst    = ($urandom_range(0, 300) == 0);
            adv();
            rst = 0;
            if (w_obs !== exp_vec) begin
                n_err++; $display("FAIL random_cyc%0d got %h want %h", c, w_obs, exp_vec);
            end
            n_vec++;
        end
    endtask

    initial begin
        rst = 1; tick = 0; reload = 0; energ = 0;
        park_all();
        test_reset();
        test_single_eat();
        test_combo();
        test_caught();
        test_double_coll();
        test_return();
        test_rst_energizer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
